alu_multicycle: RTL
===================

// Module: alu_multicycle
// PURPOSE
//   Multi-cycle integer ALU that executes the 6-bit funct code produced by the ALU control
//   decoder. Add, sub and slt complete in one cycle. Shifts run on an iterative 1-bit/cycle
//   shifter in place of a barrel shifter. Sits directly downstream of the ALU control stage.
//   The datapath waits on busy/done.
// PARAMETERS
//   WIDTH    32  operand/result width
//   SHAMT_W  5   shift-amount width (= log2(WIDTH))
// PORTS
//   clk       in   1        rising-edge clock
//   rst       in   1        synchronous reset, active-high
//   start     in   1        request; accepted only when busy==0
//   funct     in   6        operation code from ALU control
//   src1      in   WIDTH    operand A
//   src2      in   WIDTH    operand B (also the shift operand)
//   shamt     in   SHAMT_W  immediate shift amount (SLL)
//   busy      out  1        operation in flight; start ignored while high
//   done      out  1        one-cycle pulse; result/flags valid from this cycle
//   result    out  WIDTH    registered result, held until the next completion
//   zero      out  1        registered (result==0)
//   overflow  out  1        registered signed overflow (ADD/SUB only, else 0)
//   illegal   out  1        registered: funct not in the table below
// BEHAVIOUR
//   Opcodes:
//     6'b001001 ADD   result = src1 + src2
//     6'b001010 SUB   result = src1 - src2
//     6'b101010 SLT   result = {WIDTH-1 zeros, $signed(src1) < $signed(src2)}
//     6'b100001 SLL   result = src2 << shamt
//     6'b110101 SLLV  result = src2 << src1[SHAMT_W-1:0]
//     other           result = 0, illegal = 1
//   Arithmetic:
//     - Add/sub wrap modulo 2^WIDTH.
//     - overflow = operand signs match (ADD) or differ (SUB) and the result sign differs from src1.
//   Reset (rst==1 at a clock edge):
//     - state = IDLE; busy = 0, done = 0, result = 0, zero = 1, overflow = 0, illegal = 0.
//     - Reset wins over every other event, including mid-shift; the partial shift is discarded.
//   States: IDLE, SHIFT, DONE.
//     - busy = (state==SHIFT) | (accept this cycle is pending). Concretely, busy is registered
//       and high from the cycle after accept until the DONE cycle; it is low in DONE.
//     - done = (state==DONE).
//   Accept:
//     - start==1 in IDLE or DONE captures funct and operands at that edge (acc, cnt loaded).
//     - start in SHIFT is ignored; no queueing.
//   Non-shift, or shift with amount 0:
//     - accept edge -> DONE. Latency 1: done is high the cycle after accept.
//   Shift with amount k>0:
//     - accept edge -> SHIFT with acc = src2, cnt = k.
//     - Each SHIFT cycle: acc <= acc << 1, cnt <= cnt - 1.
//     - When cnt==1, the edge moves to DONE with result = final acc.
//     - done is high k+1 cycles after accept; busy is high for k cycles.
//   DONE:
//     - Lasts exactly 1 cycle, then IDLE unless start==1, which is accepted
//       (back-to-back issue with no bubble).
//   Output timing:
//     - result, zero, overflow and illegal update only on the edge entering DONE.
//     - They are stable in all other cycles.
//   Shift amounts:
//     - Only SHAMT_W bits are used, so k <= WIDTH-1.
//     - k = 31 gives result = {src2[0], 31'b0}.
//   Operands:
//     - Changing inputs after accept has no effect on the in-flight operation.
// TESTING
//   1. ADD 0x7FFFFFFF + 1, start for 1 cycle
//        -> next cycle done=1, result=0x80000000, overflow=1, zero=0.
//   2. SUB 5 - 5, then back-to-back SLT src1=-1, src2=1 with start held in the DONE cycle
//        -> done pulses on 2 consecutive cycles; results 0 (zero=1), then 1.
//   3. SLL src2=0x1, shamt=31
//        -> busy for 31 cycles, done at cycle 32 after accept, result=0x80000000;
//           start pulses during busy are ignored.
//   4. SLLV src1=0, src2=0xA5
//        -> latency 1, result=0xA5; SLLV src1=0x24 (uses 4) -> busy 4 cycles, result=0xA50.
//   5. funct=6'b000000
//        -> done next cycle, result=0, illegal=1, zero=1.
//   6. SLL shamt=10; assert rst at cycle 4 of the shift
//        -> next cycle busy=0, done=0, result=0, zero=1;
//           a new ADD 2+3 then completes with result=5.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle integer ALU: single-cycle add/sub/slt, iterative 1-bit/cycle left shifter.
// Results and flags are registered and only change on the edge that enters DONE.
module alu_multicycle #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  localparam logic [5:0] FUNCT_ADD  = 6'b001001;
  localparam logic [5:0] FUNCT_SUB  = 6'b001010;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLL  = 6'b100001;
  localparam logic [5:0] FUNCT_SLLV = 6'b110101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   acc, acc_d;
  logic [SHAMT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0]   result_d;
  logic               zero_d, overflow_d, illegal_d;
  logic               busy_d, done_d;

  // Single-cycle arithmetic, evaluated on the live operands at accept time
  logic [WIDTH-1:0]   sum, diff, slt_val, acc_shl;
  logic               add_ovf, sub_ovf;
  logic               is_shift;
  logic [SHAMT_W-1:0] shift_amt;

  // Combinational operand evaluation for the accept edge
  always_comb begin
    sum       = src1 + src2;
    diff      = src1 - src2;
    slt_val   = WIDTH'(($signed(src1) < $signed(src2)) ? 1'b1 : 1'b0);
    add_ovf   = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1]  != src1[WIDTH-1]);
    sub_ovf   = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
    acc_shl   = acc << 1;
    is_shift  = (funct == FUNCT_SLL) || (funct == FUNCT_SLLV);
    shift_amt = (funct == FUNCT_SLLV) ? src1[SHAMT_W-1:0] : shamt;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    acc_d      = acc;
    cnt_d      = cnt;
    result_d   = result;
    zero_d     = zero;
    overflow_d = overflow;
    illegal_d  = illegal;

    case (state)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (is_shift && (shift_amt != '0)) begin
            state_d = SHIFT;
            acc_d   = src2;
            cnt_d   = shift_amt;
          end else begin
            state_d    = DONE;
            overflow_d = 1'b0;
            illegal_d  = 1'b0;
            case (funct)
              FUNCT_ADD: begin
                result_d   = sum;
                overflow_d = add_ovf;
              end
              FUNCT_SUB: begin
                result_d   = diff;
                overflow_d = sub_ovf;
              end
              FUNCT_SLT:  result_d = slt_val;
              FUNCT_SLL,
              FUNCT_SLLV: result_d = src2;
              default: begin
                result_d  = '0;
                illegal_d = 1'b1;
              end
            endcase
            zero_d = (result_d == '0);
          end
        end
      end
      SHIFT: begin
        acc_d = acc_shl;
        cnt_d = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          state_d    = DONE;
          result_d   = acc_shl;
          zero_d     = (acc_shl == '0);
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      illegal  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      acc      <= acc_d;
      cnt      <= cnt_d;
      result   <= result_d;
      zero     <= zero_d;
      overflow <= overflow_d;
      illegal  <= illegal_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule
